// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Conditions raw slide-switch inputs into clean, debounced levels for the
//   logic_gate input_a port. Each bit is synchronised through a two-flop
//   chain and then has to hold a new level for DEBOUNCE_CYCLES consecutive
//   cycles before it is accepted. One-cycle pulses mark each accepted
//   transition.
//
// Ports
//   clk      in   1      system clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   sw_in    in   WIDTH  raw switch pads (asynchronous, bouncy)
//   sw_out   out  WIDTH  debounced level
//   rise     out  WIDTH  per-bit 1-cycle pulse on accepted 0->1
//   fall     out  WIDTH  per-bit 1-cycle pulse on accepted 1->0
//   changed  out  1      1-cycle pulse, OR of rise|fall over all bits
module switch_debouncer #(
   parameter int unsigned WIDTH           = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_in,
   output logic [WIDTH-1:0] sw_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   localparam int unsigned    CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0]          r_sync_1;
   logic [WIDTH-1:0]          r_sync_2;
   logic [WIDTH-1:0]          r_sw_out;
   logic [WIDTH-1:0]          r_rise;
   logic [WIDTH-1:0]          r_fall;
   logic                      r_changed;
   logic [WIDTH-1:0][CW-1:0]  r_cnt;

   logic [WIDTH-1:0][CW-1:0]  w_cnt_nxt;
   logic [WIDTH-1:0]          w_out_nxt;
   logic [WIDTH-1:0]          w_rise_nxt;
   logic [WIDTH-1:0]          w_fall_nxt;

   // Per-bit filter. The STABLE/PENDING state is implied by whether the
   // synchronised level differs from the accepted level; the counter is
   // cleared whenever the bit is stable, so any bounce back discards the
   // partial count. Acceptance at LAST keeps the counter from ever wrapping.
   always_comb begin
      w_cnt_nxt  = '0;
      w_out_nxt  = r_sw_out;
      w_rise_nxt = '0;
      w_fall_nxt = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (r_sync_2[i] != r_sw_out[i]) begin
            if (r_cnt[i] == LAST) begin
               w_out_nxt[i]  = r_sync_2[i];
               w_rise_nxt[i] = r_sync_2[i];
               w_fall_nxt[i] = ~r_sync_2[i];
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync_1  <= '0;
         r_sync_2  <= '0;
         r_sw_out  <= '0;
         r_rise    <= '0;
         r_fall    <= '0;
         r_changed <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync_1  <= sw_in;
         r_sync_2  <= r_sync_1;
         r_sw_out  <= w_out_nxt;
         r_rise    <= w_rise_nxt;
         r_fall    <= w_fall_nxt;
         r_changed <= |(w_rise_nxt | w_fall_nxt);
         r_cnt     <= w_cnt_nxt;
      end
   end

   assign sw_out  = r_sw_out;
   assign rise    = r_rise;
   assign fall    = r_fall;
   assign changed = r_changed;

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer
//   Drives two debouncer instances (DEBOUNCE_CYCLES = 4 and 1) with the same
//   directed and random switch stimulus. A reference model predicts each
//   cycle's outputs from the rule "a bit flips once the synchronised level has
//   differed from it for the last N samples"; predictions go into per-DUT
//   queues and a monitor on the falling edge pops and compares them.
module tb_switch_debouncer;

   typedef struct packed {
      logic [1:0] out;
      logic [1:0] rise;
      logic [1:0] fall;
      logic       chg;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [1:0] sw_in;

   logic [1:0] out4, rise4, fall4;
   logic       chg4;
   logic [1:0] out1, rise1, fall1;
   logic       chg1;

   int n_chk  = 0;
   int n_pass = 0;

   exp_t       q4[$];
   exp_t       q1[$];
   logic [1:0] pipe[$];   // sw_in samples still travelling through the synchroniser
   logic [1:0] hist[$];   // synchronised samples seen by the filter, oldest first
   logic [1:0] m4_out;
   logic [1:0] m1_out;

   switch_debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .sw_in(sw_in),
      .sw_out(out4), .rise(rise4), .fall(fall4), .changed(chg4)
   );

   switch_debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .sw_in(sw_in),
      .sw_out(out1), .rise(rise1), .fall(fall1), .changed(chg1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input exp_t act, input exp_t exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s @%0t: got out=%b rise=%b fall=%b changed=%b, expected out=%b rise=%b fall=%b changed=%b",
                  name, $time, act.out, act.rise, act.fall, act.chg,
                  exp.out, exp.rise, exp.fall, exp.chg);
      end
   endtask

   // A bit flips when each of the last dc synchronised samples differs from
   // its current accepted level.
   function automatic exp_t filt(input int dc, input logic [1:0] prev);
      exp_t e;
      e.out  = prev;
      e.rise = 2'b00;
      e.fall = 2'b00;
      for (int b = 0; b < 2; b++) begin
         bit all_diff;
         all_diff = (hist.size() >= dc);
         if (all_diff) begin
            for (int k = 0; k < dc; k++) begin
               if (hist[hist.size() - 1 - k][b] == prev[b]) all_diff = 1'b0;
            end
         end
         if (all_diff) begin
            e.out[b] = ~prev[b];
            if (prev[b]) e.fall[b] = 1'b1;
            else         e.rise[b] = 1'b1;
         end
      end
      e.chg = |(e.rise | e.fall);
      return e;
   endfunction

   task automatic model_reset();
      pipe.delete();
      hist.delete();
      pipe.push_back(2'b00);
      pipe.push_back(2'b00);
      m4_out = 2'b00;
      m1_out = 2'b00;
   endtask

   task automatic model_edge();
      exp_t e4, e1;
      if (!rst_n) begin
         model_reset();
         q4.push_back('0);
         q1.push_back('0);
      end else begin
         hist.push_back(pipe.pop_front());
         pipe.push_back(sw_in);
         while (hist.size() > 8) void'(hist.pop_front());
         e4 = filt(4, m4_out);
         m4_out = e4.out;
         e1 = filt(1, m1_out);
         m1_out = e1.out;
         q4.push_back(e4);
         q1.push_back(e1);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         model_edge();
         #2;
      end
   endtask

   // Assert reset after the falling-edge compare, check the asynchronous
   // clear immediately, hold it for n edges, then release mid-cycle.
   task automatic do_reset(input int n);
      #5;
      rst_n = 1'b0;
      #1;
      chk("async_reset_dc4", {out4, rise4, fall4, chg4}, '0);
      chk("async_reset_dc1", {out1, rise1, fall1, chg1}, '0);
      cycles(n);
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q4.size() > 0) begin
            e = q4.pop_front();
            chk("dc4", {out4, rise4, fall4, chg4}, e);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("dc1", {out1, rise1, fall1, chg1}, e);
         end
      end
   end

   initial begin : watchdog
      #1ms;
      $display("FAIL watchdog: simulation exceeded time limit, got running, expected finished");
      $fatal(1);
   end

   initial begin : driver
      rst_n = 1'b0;
      sw_in = 2'b11;
      model_reset();
      #3;
      chk("reset_state_dc4", {out4, rise4, fall4, chg4}, '0);
      chk("reset_state_dc1", {out1, rise1, fall1, chg1}, '0);
      cycles(2);
      rst_n = 1'b1;
      cycles(10);

      // reset from a non-zero debounced level, switches held high
      do_reset(2);
      cycles(10);

      // clean sequence 11 -> 10 -> 01 -> 00
      sw_in = 2'b10; cycles(10);
      sw_in = 2'b01; cycles(10);
      sw_in = 2'b00; cycles(10);

      // bounce on bit 0
      sw_in = 2'b01; cycles(3);
      sw_in = 2'b00; cycles(1);
      sw_in = 2'b01; cycles(10);

      // single-cycle glitch on bit 1
      sw_in = 2'b11; cycles(1);
      sw_in = 2'b01; cycles(10);

      // reset in the middle of a pending count
      sw_in = 2'b00; cycles(10);
      sw_in = 2'b01; cycles(3);
      do_reset(2);
      cycles(10);

      // simultaneous step on both bits
      sw_in = 2'b00; cycles(8);
      sw_in = 2'b11; cycles(8);

      // random stimulus with occasional resets
      for (int it = 0; it < 300; it++) begin
         sw_in = 2'($urandom());
         cycles($urandom_range(1, 8));
         if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 3));
      end

      sw_in = 2'b00;
      cycles(10);
      #10;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
